// File: rtl/rv_pkg.sv
// Shared RISC-V front-end definitions: datapath width, major opcodes and the
// fetch buffer entry that pairs an instruction word with its PC.
package rv_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush; the head is read
// combinationally so back-to-back pops need no bubble.
module fetch_fifo
   import rv_pkg::*;
#(
   parameter int  DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          flush_i,
   input  logic          push_i,
   input  fetch_entry_t  push_data_i,
   input  logic          pop_i,
   output fetch_entry_t  head_o,
   output logic [CW-1:0] count_o,
   output logic          empty_o,
   output logic          full_o
);

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked by count_q alone.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC sequencing, credit-limited memory requests, PC-tagged
// response buffering toward decode, and branch redirect with stale-response discard.
module instr_fetch_unit
   import rv_pkg::*;
#(
   parameter int              XLEN       = rv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   output logic            imem_req_valid_o,
   input  logic            imem_req_ready_i,
   output logic [XLEN-1:0] imem_req_addr_o,
   input  logic            imem_rsp_valid_i,
   input  logic [XLEN-1:0] imem_rsp_data_i,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] instr_pc_o,
   output logic [6:0]      opcode_o,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            misalign_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int SW = CW + 2;

   logic [XLEN-1:0] pc_q;
   logic [CW-1:0]   discard_q;
   logic [CW-1:0]   discard_d;
   logic            misalign_p1;

   logic            req_accept;
   logic            rsp_live;
   logic            rsp_drop;
   logic            buf_pop;
   logic [SW-1:0]   credit_used;

   fetch_entry_t    tag_push;
   fetch_entry_t    tag_head;
   logic [CW-1:0]   outstanding;
   fetch_entry_t    buf_push;
   fetch_entry_t    buf_head;
   logic [CW-1:0]   buf_count;
   logic            buf_empty;

   logic            unused_tag_empty;
   logic            unused_tag_full;
   logic            unused_buf_full;
   logic [XLEN-1:0] unused_tag_instr;

   // Credit covers buffered words, live requests in flight and stale ones still to
   // drain. The entry leaving the buffer this cycle frees its slot immediately,
   // which is what sustains one instruction per cycle with a two-entry buffer.
   assign buf_pop     = instr_valid_o && instr_ready_i;
   assign credit_used = SW'(buf_count) - SW'(buf_pop) + SW'(outstanding) + SW'(discard_q);

   assign imem_req_valid_o = rst_ni && !redirect_i && (credit_used < SW'(FIFO_DEPTH));
   assign imem_req_addr_o  = pc_q;
   assign req_accept       = imem_req_valid_o && imem_req_ready_i;

   // A response with nothing outstanding can only be left over from before reset.
   assign rsp_drop = imem_rsp_valid_i && (discard_q != '0);
   assign rsp_live = imem_rsp_valid_i && (discard_q == '0) && (outstanding != '0);

   always_comb begin
      discard_d = discard_q - CW'(rsp_drop);
      if (redirect_i) discard_d = discard_d + outstanding - CW'(rsp_live);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pc_q        <= RESET_PC;
         discard_q   <= '0;
         misalign_p1 <= 1'b0;
      end else begin
         discard_q   <= discard_d;
         misalign_p1 <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
         if (redirect_i)      pc_q <= {redirect_pc_i[XLEN-1:2], 2'b00};
         else if (req_accept) pc_q <= pc_q + XLEN'(4);
      end
   end

   assign tag_push = '{pc: pc_q, instr: '0};

   // PC tag queue: its occupancy is the count of live (non-discarded) requests.
   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_tag_q (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (redirect_i),
      .push_i      (req_accept),
      .push_data_i (tag_push),
      .pop_i       (rsp_live),
      .head_o      (tag_head),
      .count_o     (outstanding),
      .empty_o     (unused_tag_empty),
      .full_o      (unused_tag_full)
   );

   assign buf_push         = '{pc: tag_head.pc, instr: imem_rsp_data_i};
   assign unused_tag_instr = tag_head.instr;

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_buf_q (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (redirect_i),
      .push_i      (rsp_live && !redirect_i),
      .push_data_i (buf_push),
      .pop_i       (buf_pop),
      .head_o      (buf_head),
      .count_o     (buf_count),
      .empty_o     (buf_empty),
      .full_o      (unused_buf_full)
   );

   assign instr_valid_o = !buf_empty;
   assign instr_o       = buf_empty ? '0 : buf_head.instr;
   assign instr_pc_o    = buf_empty ? '0 : buf_head.pc;
   assign opcode_o      = instr_o[6:0];
   assign misalign_o    = misalign_p1;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order, fixed-latency memory model.
module tb_instr_fetch_unit;
   import rv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i;
   logic [31:0] imem_req_addr_o;
   logic        imem_rsp_valid_i;
   logic [31:0] imem_rsp_data_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic [6:0]  opcode_o;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        misalign_o;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t        pend_q[$];
   logic [31:0]  acc_q[$];
   fetch_entry_t pop_q[$];
   int           lat;
   int           cyc;
   int           n_checks;
   int           n_pass;

   instr_fetch_unit dut (
      .clk_i            (clk),
      .rst_ni           (rst_ni),
      .imem_req_valid_o (imem_req_valid_o),
      .imem_req_ready_i (imem_req_ready_i),
      .imem_req_addr_o  (imem_req_addr_o),
      .imem_rsp_valid_i (imem_rsp_valid_i),
      .imem_rsp_data_i  (imem_rsp_data_i),
      .instr_valid_o    (instr_valid_o),
      .instr_ready_i    (instr_ready_i),
      .instr_o          (instr_o),
      .instr_pc_o       (instr_pc_o),
      .opcode_o         (opcode_o),
      .redirect_i       (redirect_i),
      .redirect_pc_i    (redirect_pc_i),
      .misalign_o       (misalign_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: got no summary, required finish");
      $fatal(1);
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h0020_8033 ^ {a[24:0], 7'b0};
   endfunction

   function automatic logic [31:0] acc_at(input int i);
      return (i < acc_q.size()) ? acc_q[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] pop_pc(input int i);
      return (i < pop_q.size()) ? pop_q[i].pc : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] pop_instr(input int i);
      return (i < pop_q.size()) ? pop_q[i].instr : 32'hDEAD_BEEF;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // One clock: memory and decode observe the settled cycle at the falling edge.
   task automatic tick();
      @(negedge clk);
      imem_rsp_valid_i = 1'b0;
      if (!rst_ni) begin
         pend_q.delete();
      end else begin
         if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_word(pend_q[0].addr);
            void'(pend_q.pop_front());
         end
         if (imem_req_valid_o && imem_req_ready_i) begin
            pend_q.push_back('{imem_req_addr_o, cyc + lat});
            acc_q.push_back(imem_req_addr_o);
         end
         if (instr_valid_o && instr_ready_i)
            pop_q.push_back('{pc: instr_pc_o, instr: instr_o});
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic apply_reset();
      rst_ni           = 1'b0;
      redirect_i       = 1'b0;
      redirect_pc_i    = '0;
      instr_ready_i    = 1'b1;
      imem_req_ready_i = 1'b1;
      repeat (3) tick();
      acc_q.delete();
      pop_q.delete();
      rst_ni = 1'b1;
      #1;
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (!instr_valid_o && n < 30) begin
         tick();
         n++;
      end
      check(tag, instr_valid_o, 1'b1);
   endtask

   initial begin
      int drops;
      int pulses;
      n_checks         = 0;
      n_pass           = 0;
      cyc              = 0;
      lat              = 1;
      rst_ni           = 1'b0;
      imem_req_ready_i = 1'b1;
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
      instr_ready_i    = 1'b1;
      redirect_i       = 1'b0;
      redirect_pc_i    = '0;
      tick();
      tick();
      check("rst_req_valid", imem_req_valid_o, 1'b0);
      check("rst_instr_valid", instr_valid_o, 1'b0);
      check("rst_misalign", misalign_o, 1'b0);
      check("rst_instr", instr_o, 32'h0);
      check("rst_instr_pc", instr_pc_o, 32'h0);
      check("rst_opcode", opcode_o, 7'h0);
      check("rst_addr", imem_req_addr_o, 32'h0);

      // Streaming with single-cycle memory and an always-ready decoder.
      apply_reset();
      check("t1_req_valid_c0", imem_req_valid_o, 1'b1);
      check("t1_addr_c0", imem_req_addr_o, 32'h0);
      tick();
      check("t1_valid_c1", instr_valid_o, 1'b0);
      tick();
      check("t1_valid_c2", instr_valid_o, 1'b1);
      check("t1_pc_c2", instr_pc_o, 32'h0);
      check("t1_instr_c2", instr_o, 32'h0020_8033);
      check("t1_opcode_c2", opcode_o, OPC_RTYPE);
      drops = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!instr_valid_o) drops++;
      end
      check("t1_valid_drops", drops, 0);
      check("t1_pop_count", pop_q.size(), 10);
      for (int i = 0; i < 4; i++) begin
         check("t1_req_addr", acc_at(i), 32'(4 * i));
         check("t1_pop_pc", pop_pc(i), 32'(4 * i));
         check("t1_pop_instr", pop_instr(i), mem_word(32'(4 * i)));
      end

      // Decoder stall fills the buffer and throttles requests.
      apply_reset();
      instr_ready_i = 1'b0;
      repeat (6) tick();
      check("t2_accepts", acc_q.size(), 2);
      check("t2_req_valid", imem_req_valid_o, 1'b0);
      check("t2_instr_valid", instr_valid_o, 1'b1);
      instr_ready_i = 1'b1;
      #1;
      check("t2_head0_pc", instr_pc_o, 32'h0);
      check("t2_head0_instr", instr_o, mem_word(32'h0));
      tick();
      check("t2_head1_pc", instr_pc_o, 32'h4);
      check("t2_head1_instr", instr_o, mem_word(32'h4));

      // Memory back-pressure holds the request address.
      apply_reset();
      tick();
      tick();
      imem_req_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t3_req_valid_hold", imem_req_valid_o, 1'b1);
         check("t3_addr_hold", imem_req_addr_o, 32'h8);
         tick();
      end
      imem_req_ready_i = 1'b1;
      #1;
      check("t3_addr_release", imem_req_addr_o, 32'h8);
      repeat (8) tick();
      for (int i = 0; i < 5; i++) begin
         check("t3_req_seq", acc_at(i), 32'(4 * i));
         check("t3_pop_seq", pop_pc(i), 32'(4 * i));
      end

      // Redirect with two requests in flight.
      lat = 3;
      apply_reset();
      tick();
      tick();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h100;
      #1;
      check("t4_inflight", pend_q.size(), 2);
      check("t4_no_req_redirect", imem_req_valid_o, 1'b0);
      tick();
      redirect_i = 1'b0;
      #1;
      check("t4_empty_after", instr_valid_o, 1'b0);
      check("t4_no_misalign", misalign_o, 1'b0);
      check("t4_req_blocked", imem_req_valid_o, 1'b0);
      wait_valid("t4_valid_timeout");
      check("t4_first_pc", instr_pc_o, 32'h100);
      check("t4_first_instr", instr_o, mem_word(32'h100));
      check("t4_req_after", acc_at(2), 32'h100);

      // Back-to-back redirects; discard must account for the drop in between.
      apply_reset();
      tick();
      tick();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h200;
      tick();
      redirect_pc_i = 32'h300;
      tick();
      redirect_i = 1'b0;
      wait_valid("t5_valid_timeout");
      check("t5_first_pc", instr_pc_o, 32'h300);
      check("t5_first_instr", instr_o, mem_word(32'h300));
      check("t5_req_after", acc_at(2), 32'h300);

      // Misaligned redirect target.
      lat = 1;
      apply_reset();
      tick();
      tick();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h102;
      #1;
      check("t6_misalign_pre", misalign_o, 1'b0);
      tick();
      redirect_i = 1'b0;
      #1;
      check("t6_misalign_pulse", misalign_o, 1'b1);
      check("t6_addr_aligned", imem_req_addr_o, 32'h100);
      pulses = 1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (misalign_o) pulses++;
      end
      check("t6_pulse_count", pulses, 1);
      check("t6_pop0_pc", pop_pc(0), 32'h0);
      check("t6_pop1_pc", pop_pc(1), 32'h100);
      check("t6_pop2_pc", pop_pc(2), 32'h104);

      // Reset while the buffer is full.
      apply_reset();
      instr_ready_i = 1'b0;
      repeat (5) tick();
      check("t7_full_valid", instr_valid_o, 1'b1);
      check("t7_full_pc", instr_pc_o, 32'h0);
      rst_ni = 1'b0;
      tick();
      check("t7_rst_instr_valid", instr_valid_o, 1'b0);
      check("t7_rst_req_valid", imem_req_valid_o, 1'b0);
      check("t7_rst_pc", imem_req_addr_o, 32'h0);
      check("t7_rst_instr_pc", instr_pc_o, 32'h0);
      rst_ni        = 1'b1;
      instr_ready_i = 1'b1;
      acc_q.delete();
      pop_q.delete();
      repeat (5) tick();
      check("t7_restart_addr", acc_at(0), 32'h0);
      check("t7_restart_pc0", pop_pc(0), 32'h0);
      check("t7_restart_pc1", pop_pc(1), 32'h4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
